// File: rtl/ps2_keyboard_tx_if.sv
// ps2_keyboard_tx_if: byte-write port into the PS/2 keyboard transmitter FIFO.
//
// Handshake: a byte on data_in is taken on a rising clk edge where
// valid && ready. ready depends only on FIFO fullness and never on valid.
// A byte offered while ready is low is dropped rather than stalled, so the
// master has no obligation to hold data_in/valid.
interface ps2_keyboard_tx_if;
  logic [7:0] data_in;
  logic       valid;
  logic       ready;

  modport master (output data_in, output valid, input ready);
  modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/ps2_keyboard_tx.sv
// ps2_keyboard_tx: PS/2 device-side (keyboard) transmitter.
// Bytes are queued in an 8-entry FIFO and sent as 11-bit frames
// (start 0, 8 data bits LSB first, odd parity, stop 1), with GAP idle
// cycles between frames. ps2_clk half-period is CLK_DIV cycles.
// Optional macro PS2_TX_PARITY_ERR_EN adds err_inject, which inverts the
// parity bit of the frame popped while it is high.
module ps2_keyboard_tx #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  ps2_keyboard_tx_if.slave        bus,
`ifdef PS2_TX_PARITY_ERR_EN
  input  logic                    err_inject,
`endif
  output logic                    busy,
  output logic                    ps2_clk,
  output logic                    ps2_data,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND_HI = 2'd1,
    S_SEND_LO = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  localparam logic [15:0] HALF_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_RELOAD  = 16'(GAP - 1);

  // FIFO: 4-bit pointers, the extra MSB separates full from empty.
  logic [7:0] mem [8];
  logic [3:0] wr_ptr, rd_ptr;
  logic       empty, full, wr_en, pop;
  logic [7:0] rd_byte;
  logic       par_bit;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[3] != rd_ptr[3]) && (wr_ptr[2:0] == rd_ptr[2:0]);
  assign wr_en     = bus.valid && !full;
  assign bus.ready = !full;
  assign rd_byte   = mem[rd_ptr[2:0]];

`ifdef PS2_TX_PARITY_ERR_EN
  assign par_bit = (~^rd_byte) ^ err_inject;
`else
  assign par_bit = ~^rd_byte;
`endif

  // Pointer update; pop only ever happens on a non-empty FIFO, write only when not full.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 4'd0;
      rd_ptr <= 4'd0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 4'd1;
      if (pop)   rd_ptr <= rd_ptr + 4'd1;
    end
  end

  // Storage array, no reset needed: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[2:0]] <= bus.data_in;
  end

  // Frame sequencer state.
  state_t      state_q, state_n;
  logic [15:0] cnt_q, cnt_n;
  logic [3:0]  idx_q, idx_n;
  logic [10:0] frame_q, frame_n;
  logic        ps2_clk_q, ps2_clk_n;
  logic        ps2_data_q, ps2_data_n;

  // State register; line outputs are registered so they are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      idx_q      <= 4'd0;
      frame_q    <= 11'h7ff;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      idx_q      <= idx_n;
      frame_q    <= frame_n;
      ps2_clk_q  <= ps2_clk_n;
      ps2_data_q <= ps2_data_n;
    end
  end

  // Next state and next line values; the counter reloads on every state entry,
  // and ps2_data only changes when entering SEND_HI (or returning to idle high).
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    idx_n      = idx_q;
    frame_n    = frame_q;
    ps2_clk_n  = ps2_clk_q;
    ps2_data_n = ps2_data_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        ps2_clk_n  = 1'b1;
        ps2_data_n = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          frame_n    = {1'b1, par_bit, rd_byte, 1'b0};
          idx_n      = 4'd0;
          cnt_n      = HALF_RELOAD;
          state_n    = S_SEND_HI;
          ps2_data_n = 1'b0;
        end
      end
      S_SEND_HI: begin
        if (cnt_q == 16'd0) begin
          state_n   = S_SEND_LO;
          cnt_n     = HALF_RELOAD;
          ps2_clk_n = 1'b0;
        end else begin
          cnt_n = cnt_q - 16'd1;
        end
      end
      S_SEND_LO: begin
        if (cnt_q == 16'd0) begin
          ps2_clk_n = 1'b1;
          if (idx_q == 4'd10) begin
            state_n    = S_GAP;
            cnt_n      = GAP_RELOAD;
            ps2_data_n = 1'b1;
          end else begin
            idx_n      = idx_q + 4'd1;
            state_n    = S_SEND_HI;
            cnt_n      = HALF_RELOAD;
            ps2_data_n = frame_q[idx_q + 4'd1];
          end
        end else begin
          cnt_n = cnt_q - 16'd1;
        end
      end
      S_GAP: begin
        ps2_clk_n  = 1'b1;
        ps2_data_n = 1'b1;
        if (cnt_q == 16'd0) state_n = S_IDLE;
        else                cnt_n   = cnt_q - 16'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign ps2_clk   = ps2_clk_q;
  assign ps2_data  = ps2_data_q;
  assign busy      = (state_q != S_IDLE) || !empty;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// tb_ps2_keyboard_tx: directed bench for ps2_keyboard_tx (CLK_DIV=4, GAP=8).
// A receiver model decodes frames from the lines; decoded bytes are checked
// against an expected queue. Define PS2_TX_PARITY_ERR_EN to add the
// parity-injection vectors.
`timescale 1ns/1ps
module tb_ps2_keyboard_tx;

  localparam int CLK_DIV = 4;
  localparam int GAP     = 8;
  localparam int FRAME_CYC = 22 * CLK_DIV;

  typedef struct packed {
    logic [7:0]  data;
    logic        err;
    logic [10:0] exp_frame;
    logic        exp_ok;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_keyboard_tx_if bus();
  logic       busy, ps2_clk, ps2_data;
  logic [1:0] state_dbg;
`ifdef PS2_TX_PARITY_ERR_EN
  logic err_inject = 1'b0;
`endif

  ps2_keyboard_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
`ifdef PS2_TX_PARITY_ERR_EN
    .err_inject(err_inject),
`endif
    .busy      (busy),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- receiver model ----------------
  int          bitcnt = 0;
  int          n_fall = 0;
  int          n_frames = 0;
  int          busy_fall_cyc = 0;
  int          start_q[$];
  logic [10:0] cur = '0;
  logic [10:0] last_frame = '0;
  logic        prev_clk = 1'b1, prev_data = 1'b1, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      bitcnt = 0;
    end else begin
      if (bitcnt == 0 && prev_data && !ps2_data && ps2_clk) start_q.push_back(cyc);
      if (prev_clk && !ps2_clk) begin
        cur[bitcnt] = ps2_data;
        bitcnt++;
        n_fall++;
        if (bitcnt == 11) begin
          bitcnt = 0;
          n_frames++;
          last_frame = cur;
          if (!cur[0] && cur[10] && (^cur[9:1])) begin
            if (exp_q.size() == 0) check("rx_unexpected_byte", {24'd0, cur[8:1]}, 32'hffff_ffff);
            else check("rx_byte", {24'd0, cur[8:1]}, {24'd0, exp_q.pop_front()});
          end
        end
      end
      if (prev_busy && !busy) busy_fall_cyc = cyc;
    end
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
    prev_busy = busy;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ok, output int acc);
    bus.data_in = d;
    bus.valid   = 1'b1;
    ok  = bus.ready;
    acc = cyc;
    step();
    bus.valid = 1'b0;
  endtask

  task automatic wait_idle(input int target_frames, input int budget, output logic timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (n_frames >= target_frames && !busy) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic e, input logic [10:0] f, input logic ok);
    vec_t v;
    v.data = d; v.err = e; v.exp_frame = f; v.exp_ok = ok;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    int   f0, fall0, s0, acc;
    logic ok, tmo;
    f0 = n_frames; fall0 = n_fall; s0 = start_q.size();
`ifdef PS2_TX_PARITY_ERR_EN
    err_inject = v.err;
`endif
    if (v.exp_ok) exp_q.push_back(v.data);
    write_byte(v.data, ok, acc);
    check("vec_accept", {31'd0, ok}, 32'd1);
    wait_idle(f0 + 1, 400, tmo);
    check("vec_timeout", {31'd0, tmo}, 32'd0);
    check("vec_frame_bits", {21'd0, last_frame}, {21'd0, v.exp_frame});
    check("vec_fall_edges", n_fall - fall0, 32'd11);
    check("vec_start_seen", {31'd0, start_q.size() > s0}, 32'd1);
    if (start_q.size() > s0) begin
      check("vec_start_latency", start_q[s0] - acc, 32'd2);
      check("vec_busy_drop", busy_fall_cyc - start_q[s0], FRAME_CYC + GAP);
    end
`ifdef PS2_TX_PARITY_ERR_EN
    err_inject = 1'b0;
`endif
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[$];

  initial begin
    int   f0, s0, fall0;
    logic tmo;
    logic rdy [10];

    vecs.push_back(mk(8'h1C, 1'b0, 11'h438, 1'b1));
    vecs.push_back(mk(8'h00, 1'b0, 11'h600, 1'b1));
    vecs.push_back(mk(8'hF0, 1'b0, 11'h7E0, 1'b1));
    vecs.push_back(mk(8'hFF, 1'b0, 11'h7FE, 1'b1));
    vecs.push_back(mk(8'h01, 1'b0, 11'h402, 1'b1));
    vecs.push_back(mk(8'h32, 1'b0, 11'h464, 1'b1));
    vecs.push_back(mk(8'hA5, 1'b0, 11'h74A, 1'b1));
`ifdef PS2_TX_PARITY_ERR_EN
    vecs.push_back(mk(8'h1C, 1'b1, 11'h638, 1'b0));
    vecs.push_back(mk(8'h32, 1'b0, 11'h464, 1'b1));
`endif

    rst = 1'b1;
    bus.valid = 1'b0;
    bus.data_in = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_ps2_clk", {31'd0, ps2_clk}, 32'd1);
    check("rst_ps2_data", {31'd0, ps2_data}, 32'd1);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);

    // Single-byte frames from the vector table.
    foreach (vecs[i]) apply_vec(vecs[i]);

    // Back-to-back bytes: start edges one frame + gap + idle cycle apart.
    f0 = n_frames; s0 = start_q.size();
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h1C);
    bus.valid = 1'b1;
    bus.data_in = 8'hF0;
    step();
    bus.data_in = 8'h1C;
    step();
    bus.valid = 1'b0;
    wait_idle(f0 + 2, 600, tmo);
    check("b2b_timeout", {31'd0, tmo}, 32'd0);
    check("b2b_frames", n_frames - f0, 32'd2);
    check("b2b_starts", start_q.size() - s0, 32'd2);
    if (start_q.size() >= s0 + 2)
      check("b2b_spacing", start_q[s0 + 1] - start_q[s0], FRAME_CYC + GAP + 1);

    // Ten writes while the first frame is in flight: 9 accepted, 10th dropped.
    f0 = n_frames;
    for (int k = 0; k < 9; k++) exp_q.push_back(8'h40 + 8'(k));
    for (int k = 0; k < 10; k++) begin
      bus.data_in = 8'h40 + 8'(k);
      bus.valid = 1'b1;
      rdy[k] = bus.ready;
      step();
    end
    bus.valid = 1'b0;
    for (int k = 0; k < 10; k++) check($sformatf("fill_ready_%0d", k), {31'd0, rdy[k]}, (k < 9) ? 32'd1 : 32'd0);
    wait_idle(f0 + 9, 2500, tmo);
    check("fill_timeout", {31'd0, tmo}, 32'd0);
    repeat (50) step();
    check("fill_frames", n_frames - f0, 32'd9);

    // Reset during data bit 4 (frame bit 5) with another byte still queued.
    f0 = n_frames;
    bus.valid = 1'b1;
    bus.data_in = 8'hA5;
    step();
    bus.data_in = 8'h32;
    step();
    bus.valid = 1'b0;
    for (int i = 0; i < 600 && bitcnt != 6; i++) step();
    check("mid_rst_reached_bit", bitcnt, 32'd6);
    rst = 1'b1;
    step();
    check("mid_rst_ps2_clk", {31'd0, ps2_clk}, 32'd1);
    check("mid_rst_ps2_data", {31'd0, ps2_data}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.ready}, 32'd1);
    rst = 1'b0;
    fall0 = n_fall; s0 = start_q.size();
    repeat (400) step();
    check("mid_rst_no_edges", n_fall - fall0, 32'd0);
    check("mid_rst_no_starts", start_q.size() - s0, 32'd0);
    check("mid_rst_no_frames", n_frames - f0, 32'd0);
    check("mid_rst_busy_after", {31'd0, busy}, 32'd0);

    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case something above never returns.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000ns");
    $fatal(1, "global timeout");
  end

endmodule
